addsub_pipe: RTL and testbench

Parametrised, pipelined two's-complement adder/subtractor with a valid/ready stream interface and result flags. It succeeds the fixed 4-bit ripple add/sub:
- Operand width is generic.
- The carry chain is split into CHUNK-bit slices, with one register stage per slice, so wide operands close timing at one result per cycle.
- It sits between operand-issue logic and any result consumer that can apply backpressure.

---
 rtl/addsub_pkg.sv | 14 +
 rtl/addsub_slice.sv | 16 +
 rtl/addsub_pipe.sv | 92 +++++++++
 tb/tb_addsub_pipe.sv | 224 ++++++++++++++++++++++
 4 files changed

// File: rtl/addsub_pkg.sv
// addsub_pkg: shared sizing helper and flag record for the pipelined add/sub
package addsub_pkg;

    typedef struct packed {
        logic cout;
        logic ovf;
        logic zero;
    } flags_t;

    function automatic int stages(input int width, input int chunk);
        return width / chunk;
    endfunction

endpackage

// File: rtl/addsub_slice.sv
// addsub_slice: combinational CHUNK-bit adder slice with carry into its MSB
module addsub_slice #(
    parameter int CHUNK = 4
) (
    input  logic [CHUNK-1:0] a,
    input  logic [CHUNK-1:0] b,
    input  logic             cin,
    output logic [CHUNK-1:0] s,
    output logic             cout,
    output logic             c_msb
);
    always_comb begin
        {cout, s} = {1'b0, a} + {1'b0, b} + {{CHUNK{1'b0}}, cin};
        c_msb = s[CHUNK-1] ^ a[CHUNK-1] ^ b[CHUNK-1];
    end
endmodule

// File: rtl/addsub_pipe.sv
// addsub_pipe: skewed add/sub pipeline, one CHUNK-bit carry slice per stage, global stall
module addsub_pipe
    import addsub_pkg::*;
#(
    parameter int WIDTH = 16,
    parameter int CHUNK = 4
) (
    input  logic             clk,
    input  logic             rst_n,
    input  logic             in_valid,
    output logic             in_ready,
    input  logic [WIDTH-1:0] a,
    input  logic [WIDTH-1:0] b,
    input  logic             sub,
    output logic             out_valid,
    input  logic             out_ready,
    output logic [WIDTH-1:0] s,
    output logic             cout,
    output logic             ovf,
    output logic             zero
);
    localparam int STAGES = stages(WIDTH, CHUNK);
    localparam int L = STAGES - 1;

    if (WIDTH % CHUNK != 0 || WIDTH < CHUNK) begin : g_bad_cfg
        $error("addsub_pipe: WIDTH must be a nonzero multiple of CHUNK");
    end

    typedef struct packed {
        logic [WIDTH-1:0] a;
        logic [WIDTH-1:0] b;
        logic [WIDTH-1:0] s;
        logic             c;
        logic             v;
    } stage_t;

    logic   advance;
    flags_t flg;

    assign advance = !out_valid || out_ready;
    assign in_ready = advance;

    for (genvar k = 0; k < STAGES; k++) begin : g_st
        stage_t           src;
        stage_t           nxt;
        stage_t           q;
        logic [CHUNK-1:0] sum;
        logic             co;
        logic             cm;
        logic             unused;
        if (k == 0) begin : g_src
            assign src = '{a: a, b: b ^ {WIDTH{sub}}, s: '0, c: sub, v: in_valid};
        end else begin : g_src
            assign src = g_st[k-1].q;
        end
        addsub_slice #(.CHUNK(CHUNK)) u_slice (
            .a    (src.a[k*CHUNK +: CHUNK]),
            .b    (src.b[k*CHUNK +: CHUNK]),
            .cin  (src.c),
            .s    (sum),
            .cout (co),
            .c_msb(cm)
        );
        always_comb begin
            nxt = src;
            nxt.s[k*CHUNK +: CHUNK] = sum;
            nxt.c = co;
        end
        always_ff @(posedge clk or negedge rst_n) begin
            if (!rst_n) q <= '0;
            else if (advance) q <= nxt;
        end
        // operands and carry are spent once the top slice has been resolved
        if (k == L) begin : g_sink
            assign unused = ^{q.a, q.b, q.c};
        end else begin : g_sink
            assign unused = cm;
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) flg <= '0;
        else if (advance) flg <= '{cout: g_st[L].co, ovf: g_st[L].co ^ g_st[L].cm, zero: ~|g_st[L].nxt.s};
    end

    assign out_valid = g_st[L].q.v;
    assign s = g_st[L].q.s;
    assign cout = flg.cout;
    assign ovf = flg.ovf;
    assign zero = flg.zero;

endmodule

// File: tb/tb_addsub_pipe.sv
// tb_addsub_pipe: randomized and directed checks of addsub_pipe against an arithmetic model
module tb_addsub_pipe;

    typedef struct packed {
        logic [15:0] s;
        logic        cout;
        logic        ovf;
        logic        zero;
    } res_t;

    logic        clk = 1'b0;
    logic        rst_n = 1'b0;
    logic        in_valid = 1'b0;
    logic        out_ready = 1'b1;
    logic        sub = 1'b0;
    logic [15:0] a = '0;
    logic [15:0] b = '0;
    logic        in_ready;
    logic        out_valid;
    logic        cout;
    logic        ovf;
    logic        zero;
    logic [15:0] s;

    int   checks = 0;
    int   errors = 0;
    int   pushed = 0;
    int   popped = 0;
    int   base_p;
    int   base_r;
    int   wait_n;
    res_t exp_q[$];
    res_t e;
    res_t held_val;
    logic held = 1'b0;
    logic [15:0] r;

    always #5 clk = ~clk;

    addsub_pipe #(.WIDTH(16), .CHUNK(4)) dut (
        .clk      (clk),
        .rst_n    (rst_n),
        .in_valid (in_valid),
        .in_ready (in_ready),
        .a        (a),
        .b        (b),
        .sub      (sub),
        .out_valid(out_valid),
        .out_ready(out_ready),
        .s        (s),
        .cout     (cout),
        .ovf      (ovf),
        .zero     (zero)
    );

    task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
        checks++;
        if (got !== exp) begin
            errors++;
            $display("FAIL %s got=%0h exp=%0h", tag, got, exp);
        end
    endtask

    function automatic res_t model(input logic [15:0] x, input logic [15:0] y, input logic sb);
        int   sx = int'($signed(x));
        int   sy = int'($signed(y));
        int   res = sb ? sx - sy : sx + sy;
        res_t m;
        m.s = 16'(res);
        m.cout = sb ? (x >= y) : (int'(x) + int'(y) > 65535);
        m.ovf = res > 32767 || res < -32768;
        m.zero = m.s == 16'h0000;
        return m;
    endfunction

    always @(negedge clk) begin
        if (!rst_n) held = 1'b0;
        else begin
            if (held) begin
                chk("hold_valid", 32'(out_valid), 32'd1);
                chk("hold_data", 32'({s, cout, ovf, zero}), 32'(held_val));
            end
            if (out_valid && out_ready) begin
                if (exp_q.size() == 0) chk("unexpected_beat", 32'd1, 32'd0);
                else begin
                    e = exp_q.pop_front();
                    chk("result", 32'({s, cout, ovf, zero}), 32'(e));
                    popped++;
                end
            end
            if (in_valid && in_ready) begin
                exp_q.push_back(model(a, b, sub));
                pushed++;
            end
            held = out_valid && !out_ready;
            held_val = '{s, cout, ovf, zero};
        end
    end

    task automatic one(input string tag, input logic [15:0] x, input logic [15:0] y, input logic sb,
                       input logic [15:0] es, input logic ec, input logic eo, input logic ez);
        int n = 1;
        a = x;
        b = y;
        sub = sb;
        in_valid = 1'b1;
        @(posedge clk);
        #1 in_valid = 1'b0;
        while (!out_valid && n < 20) begin
            @(posedge clk);
            #1 n++;
        end
        chk({tag, "_lat"}, n, 32'd4);
        chk({tag, "_s"}, 32'(s), 32'(es));
        chk({tag, "_cout"}, 32'(cout), 32'(ec));
        chk({tag, "_ovf"}, 32'(ovf), 32'(eo));
        chk({tag, "_zero"}, 32'(zero), 32'(ez));
    endtask

    task automatic drive(input logic [15:0] x, input logic [15:0] y, input logic sb);
        int n = 0;
        a = x;
        b = y;
        sub = sb;
        in_valid = 1'b1;
        @(negedge clk);
        while (!in_ready && n < 50) begin
            @(negedge clk);
            n++;
        end
        if (n >= 50) chk("accept_timeout", n, 32'd0);
        @(posedge clk);
        #1 in_valid = 1'b0;
    endtask

    task automatic drain(input string tag);
        int n = 0;
        while ((exp_q.size() != 0 || out_valid) && n < 50) begin
            @(posedge clk);
            #1 n++;
        end
        chk(tag, exp_q.size(), 32'd0);
    endtask

    initial begin
        #200000;
        $display("FAIL watchdog expired");
        $fatal(1, "timeout");
    end

    initial begin
        repeat (2) @(negedge clk);
        chk("rst_valid", 32'(out_valid), 32'd0);
        chk("rst_s", 32'(s), 32'd0);
        chk("rst_cout", 32'(cout), 32'd0);
        chk("rst_ovf", 32'(ovf), 32'd0);
        chk("rst_zero", 32'(zero), 32'd0);
        chk("rst_in_ready", 32'(in_ready), 32'd1);
        @(posedge clk);
        #1 rst_n = 1'b1;
        repeat (3) @(negedge clk);
        chk("idle_valid", 32'(out_valid), 32'd0);
        chk("idle_in_ready", 32'(in_ready), 32'd1);
        @(posedge clk);
        #1;
        one("add_carry", 16'h00FF, 16'h0001, 1'b0, 16'h0100, 1'b0, 1'b0, 1'b0);
        one("add_ovf", 16'h7FFF, 16'h0001, 1'b0, 16'h8000, 1'b0, 1'b1, 1'b0);
        one("add_chain", 16'hFFFF, 16'h0001, 1'b0, 16'h0000, 1'b1, 1'b0, 1'b1);
        one("sub_eq", 16'h0005, 16'h0005, 1'b1, 16'h0000, 1'b1, 1'b0, 1'b1);
        one("sub_neg", 16'h0003, 16'h0005, 1'b1, 16'hFFFE, 1'b0, 1'b0, 1'b0);
        one("sub_ovf", 16'h8000, 16'h0001, 1'b1, 16'h7FFF, 1'b1, 1'b1, 1'b0);
        for (int i = 0; i < 4; i++) begin
            r = 16'($urandom);
            one("sub_b0", r, 16'h0000, 1'b1, r, 1'b1, 1'b0, r == 16'h0000);
        end
        drain("pre_bp_drain");
        base_p = pushed;
        base_r = popped;
        fork
            for (int i = 0; i < 8; i++) drive(16'($urandom), 16'($urandom), 1'($urandom));
            begin
                repeat (5) @(posedge clk);
                #1 out_ready = 1'b0;
                repeat (3) begin
                    @(negedge clk);
                    chk("stall_in_ready", 32'(in_ready), 32'd0);
                end
                @(posedge clk);
                #1 out_ready = 1'b1;
            end
        join
        drain("bp_drain");
        chk("bp_pushed", pushed - base_p, 32'd8);
        chk("bp_popped", popped - base_r, 32'd8);
        out_ready = 1'b0;
        for (int i = 0; i < 3; i++) drive(16'($urandom), 16'($urandom), 1'($urandom));
        wait_n = 0;
        while (!out_valid && wait_n < 20) begin
            @(posedge clk);
            #1 wait_n++;
        end
        chk("pre_rst_valid", 32'(out_valid), 32'd1);
        #2 rst_n = 1'b0;
        #1;
        chk("async_valid", 32'(out_valid), 32'd0);
        chk("async_s", 32'(s), 32'd0);
        chk("async_in_ready", 32'(in_ready), 32'd1);
        exp_q.delete();
        @(posedge clk);
        #1 rst_n = 1'b1;
        out_ready = 1'b1;
        repeat (6) begin
            @(negedge clk);
            chk("no_stale", 32'(out_valid), 32'd0);
        end
        @(posedge clk);
        #1;
        one("post_rst", 16'h1234, 16'h4321, 1'b0, 16'h5555, 1'b0, 1'b0, 1'b0);
        drain("final_drain");
        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
